demux_rr_scheduler: RTL and testbench
=====================================

# demux_rr_scheduler

Round-robin scheduler placed directly upstream of the 1-to-4 demultiplexer. It accepts a serial bit stream over a valid/ready handshake and assigns consecutive bursts of bits to the four demux outputs in turn. Disabled channels are skipped. For each accepted bit it drives the demux select code and data bit, and it keeps a per-channel count of delivered bits.

## Interface
- `BURST`, default 4: bits delivered to one channel before advancing; legal range 1..16.
- `CNT_W`, default 8: width of each per-channel bit counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_mask`  in  4  channel enables; bit k enables demux output k; sampled every cycle.
- `in_valid`  in  1  upstream bit available.
- `in_bit`  in  1  data bit; meaningful when `in_valid`=1.
- `in_ready`  out  1  combinational: scheduler accepts a bit this cycle.
- `cnt_clr`  in  1  synchronous clear of all channel counters.
- `sel`  out  2  registered channel select to the demux.
- `I`  out  1  registered data bit to the demux.
- `out_valid`  out  1  registered; 1-cycle strobe marking `sel`/`I` as a new delivery.
- `ch_cnt`  out  4*CNT_W  registered per-channel bit counters; channel k occupies bits [k*CNT_W +: CNT_W].

## Operation
- Internal state: FSM {IDLE, RUN}, `cur_ch`[1:0], `burst_cnt` [$clog2(BURST) bits, minimum 1].
- "Next enabled after c": the first k in the cyclic order c+1, c+2, c+3, c+4 (mod 4) with `en_mask`[k]=1. If c is the only enabled channel, the result is c.
- `in_ready` = (state==RUN) && `en_mask`[`cur_ch`].
- A transfer occurs when `in_valid` && `in_ready`.
- IDLE:
  - Entered from reset, or from RUN whenever `en_mask`==0.
  - While `en_mask`==0: stay in IDLE and hold `cur_ch`.
  - When `en_mask`!=0: go to RUN. `cur_ch` is kept if still enabled, otherwise it becomes the next enabled channel after it. `burst_cnt` is set to 0.
- RUN, on a transfer:
  - `I` <= `in_bit`, `sel` <= `cur_ch`, `out_valid` <= 1.
  - `ch_cnt`[`cur_ch`] increments, wrapping modulo 2^CNT_W.
  - If `burst_cnt`==BURST-1: `burst_cnt` <= 0 and `cur_ch` <= next enabled after `cur_ch`. Otherwise `burst_cnt` increments.
- RUN, no transfer: `out_valid` <= 0, `I` <= 0, `sel` holds. The demux output is therefore all-zero between deliveries.
- RUN, `en_mask`!=0 but `en_mask`[`cur_ch`]=0: no transfer. The burst is aborted: next cycle `cur_ch` <= next enabled after `cur_ch` and `burst_cnt` <= 0.
- RUN, `en_mask`==0: go to IDLE, `burst_cnt` <= 0, `cur_ch` holds.
- `cnt_clr`=1 zeroes all counters and wins over a simultaneous increment, leaving that channel at 0.
- Only transfers advance `burst_cnt`. `in_valid` gaps stretch a burst but never shorten it.

## Timing
- Reset values: state IDLE, `cur_ch`=0, `burst_cnt`=0, `sel`=0, `I`=0, `out_valid`=0, all `ch_cnt`=0. `in_ready`=0 while in reset and in IDLE.
- Latency: a transfer at edge N produces `sel`/`I`/`out_valid` valid after edge N, for exactly one cycle unless another transfer follows.
- Throughput: one bit per cycle. Back-to-back bursts have no bubble when switching channels.
- IDLE->RUN costs one cycle. The first `in_ready` is asserted in the cycle after `en_mask` becomes nonzero.
- A mask change affects `in_ready` in the same cycle (combinational path); pointer movement takes effect at the next edge.
- Reset asserted mid-burst clears everything immediately. A partially delivered burst is not resumed.

## Test plan
- Reset checks:
  - Assert `rst_n`=0 mid-stream -> all outputs zero immediately.
  - First `in_ready` appears one cycle after release, with `en_mask`=4'hF.
- Full round-robin:
  - BURST=4, `en_mask`=4'hF, 16 continuous bits 1 -> `sel` sequence 0,0,0,0,1,1,1,1,2,…,3.
  - Every `ch_cnt`=4.
- Skip disabled channels:
  - `en_mask`=4'b0101, 12 bits -> `sel` visits only 0 and 2 (0,2,0 bursts).
  - `ch_cnt`[1] and `ch_cnt`[3] stay 0.
- Mid-burst disable:
  - Clear `en_mask`[0] after 2 bits on channel 0 -> one no-transfer cycle.
  - Next burst on channel 1 delivers 4 full bits.
- Mask zero and backpressure:
  - `en_mask`=0 -> IDLE with `in_ready`=0.
  - Re-enable with 4'b1000 -> `cur_ch`=3.
  - Toggle `in_valid` every other cycle -> bursts still 4 bits long.
  - `I`=0 and `out_valid`=0 on gap cycles.
- Counter wrap and clear:
  - CNT_W=8, 256 bits to a single channel -> counter wraps to 0.
  - `cnt_clr` on a transfer cycle -> that counter reads 0, not 1.

Source files
------------

// File: rtl/demux_rr_if.sv
// Bit-stream handshake into the scheduler and the registered select/data pair
// it drives into the 1-to-4 demultiplexer.
interface demux_rr_if;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic [1:0] sel;
    logic       I;
    logic       out_valid;

    modport master (output in_valid, in_bit, input in_ready, sel, I, out_valid);
    modport slave  (input in_valid, in_bit, output in_ready, sel, I, out_valid);
endinterface

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler feeding a 1-to-4 demux: hands out BURST-bit bursts to
// the enabled channels in turn and counts delivered bits per channel.
module demux_rr_scheduler #(
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         en_mask,
    input  logic               cnt_clr,
    demux_rr_if.slave          bus,
    output logic [4*CNT_W-1:0] ch_cnt
);

    localparam int BC_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cur_ch_q, cur_ch_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             i_q, i_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] ch_cnt_q [4];
    logic [CNT_W-1:0] ch_cnt_d [4];
    logic             in_ready;
    logic             transfer;

    // Cyclic search c+1..c+4; the last candidate is c itself, so a lone
    // enabled channel keeps the pointer where it is.
    function automatic logic [1:0] next_enabled(input logic [1:0] c, input logic [3:0] mask);
        logic [1:0] k;
        logic       found;
        next_enabled = c;
        found        = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            k = c + 2'(i);
            if (!found && mask[k]) begin
                next_enabled = k;
                found        = 1'b1;
            end
        end
    endfunction

    assign in_ready = (state_q == S_RUN) && en_mask[cur_ch_q];
    assign transfer = bus.in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        burst_cnt_d = burst_cnt_q;
        sel_d       = sel_q;
        i_d         = 1'b0;
        out_valid_d = 1'b0;
        ch_cnt_d    = ch_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (en_mask != 4'b0000) begin
                    state_d     = S_RUN;
                    burst_cnt_d = '0;
                    if (!en_mask[cur_ch_q]) cur_ch_d = next_enabled(cur_ch_q, en_mask);
                end
            end
            S_RUN: begin
                if (en_mask == 4'b0000) begin
                    state_d     = S_IDLE;
                    burst_cnt_d = '0;
                end else if (!en_mask[cur_ch_q]) begin
                    // Current channel was disabled mid-burst: abandon it.
                    cur_ch_d    = next_enabled(cur_ch_q, en_mask);
                    burst_cnt_d = '0;
                end else if (transfer) begin
                    sel_d              = cur_ch_q;
                    i_d                = bus.in_bit;
                    out_valid_d        = 1'b1;
                    ch_cnt_d[cur_ch_q] = ch_cnt_q[cur_ch_q] + 1'b1;
                    if (burst_cnt_q == BURST_LAST) begin
                        burst_cnt_d = '0;
                        cur_ch_d    = next_enabled(cur_ch_q, en_mask);
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cnt_clr) begin
            for (int k = 0; k < 4; k++) ch_cnt_d[k] = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_ch_q    <= 2'd0;
            burst_cnt_q <= '0;
            sel_q       <= 2'd0;
            i_q         <= 1'b0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) ch_cnt_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            burst_cnt_q <= burst_cnt_d;
            sel_q       <= sel_d;
            i_q         <= i_d;
            out_valid_q <= out_valid_d;
            ch_cnt_q    <= ch_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sel       = sel_q;
    assign bus.I         = i_q;
    assign bus.out_valid = out_valid_q;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign ch_cnt[g*CNT_W +: CNT_W] = ch_cnt_q[g];
    end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler: vector tables with hand-computed
// expectations plus reset, wrap and clear sequences.
module tb_demux_rr_scheduler;
    localparam int BURST = 4;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         en_mask = 4'h0;
    logic               cnt_clr = 1'b0;
    logic [4*CNT_W-1:0] ch_cnt;

    demux_rr_if bus ();

    demux_rr_scheduler #(.BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_mask (en_mask),
        .cnt_clr (cnt_clr),
        .bus     (bus),
        .ch_cnt  (ch_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] mask;
        logic       valid;
        logic       b;
        logic       clr;
        logic       exp_ready;
        logic       exp_valid;
        logic [1:0] exp_sel;
        logic       exp_i;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] mask, input logic valid, input logic b,
                                input logic clr, input logic rdy, input logic ov,
                                input logic [1:0] sel, input logic i);
        vec_t v;
        v.mask = mask; v.valid = valid; v.b = b; v.clr = clr;
        v.exp_ready = rdy; v.exp_valid = ov; v.exp_sel = sel; v.exp_i = i;
        vecs.push_back(v);
    endfunction

    // Inputs are applied 1 time unit after a rising edge; in_ready is checked
    // before the next edge, registered outputs 1 unit after it.
    task automatic run_vectors(input string tag);
        foreach (vecs[n]) begin
            en_mask      = vecs[n].mask;
            bus.in_valid = vecs[n].valid;
            bus.in_bit   = vecs[n].b;
            cnt_clr      = vecs[n].clr;
            #1;
            check($sformatf("%s[%0d] in_ready", tag, n), bus.in_ready, vecs[n].exp_ready);
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d] out_valid", tag, n), bus.out_valid, vecs[n].exp_valid);
            check($sformatf("%s[%0d] sel", tag, n), bus.sel, vecs[n].exp_sel);
            check($sformatf("%s[%0d] I", tag, n), bus.I, vecs[n].exp_i);
        end
        vecs.delete();
        bus.in_valid = 1'b0;
        cnt_clr      = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int c0, input int c1, input int c2, input int c3);
        int exp[4];
        exp = '{c0, c1, c2, c3};
        for (int k = 0; k < 4; k++)
            check($sformatf("%s ch_cnt[%0d]", tag, k), ch_cnt[k*CNT_W +: CNT_W], exp[k]);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        #2;
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset sel", bus.sel, 0);
        check("reset I", bus.I, 0);
        check_cnts("reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full round-robin: IDLE->RUN cycle, then 16 bits in bursts of 4.
        add(4'hF, 1, 1, 0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 16; i++) add(4'hF, 1, 1, 0, 1, 1, 2'(i / 4), 1);
        run_vectors("rr");
        check_cnts("rr", 4, 4, 4, 4);

        // Mid-burst disable of channel 0 after 2 bits; channel 1 gets a full burst.
        add(4'hF, 1, 1, 0, 1, 1, 2'd0, 1);
        add(4'hF, 1, 0, 0, 1, 1, 2'd0, 0);
        add(4'hE, 1, 1, 0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) add(4'hE, 1, 1, 0, 1, 1, 2'd1, 1);
        run_vectors("abort");
        check_cnts("abort", 6, 8, 4, 4);

        // Clear counters, then skip disabled channels 1 and 3.
        add(4'b0101, 0, 1, 1, 1, 0, 2'd1, 0);
        for (int i = 0; i < 12; i++) add(4'b0101, 1, 1, 0, 1, 1, ((i / 4) == 1) ? 2'd0 : 2'd2, 1);
        run_vectors("skip");
        check_cnts("skip", 4, 0, 8, 0);

        // Mask to zero -> IDLE; re-enable on channel 3 only; then gapped bursts.
        add(4'h0, 1, 1, 0, 0, 0, 2'd2, 0);
        add(4'h0, 1, 1, 0, 0, 0, 2'd2, 0);
        add(4'b1000, 1, 1, 0, 0, 0, 2'd2, 0);
        for (int t = 0; t < 8; t++) begin
            add(4'hF, 1, 1, 0, 1, 1, (t < 4) ? 2'd3 : 2'd0, 1);
            add(4'hF, 0, 1, 0, 1, 0, (t < 4) ? 2'd3 : 2'd0, 0);
        end
        run_vectors("gap");
        check_cnts("gap", 8, 0, 8, 4);

        // Counter wrap on channel 1 alone.
        add(4'b0010, 0, 0, 1, 1, 0, 2'd0, 0);
        run_vectors("wclr");
        check_cnts("wclr", 0, 0, 0, 0);
        for (int i = 0; i < 255; i++) add(4'b0010, 1, 1'(i), 0, 1, 1, 2'd1, 1'(i));
        run_vectors("wrap");
        check("wrap ch_cnt[1] at 255", ch_cnt[CNT_W +: CNT_W], 255);
        add(4'b0010, 1, 1, 0, 1, 1, 2'd1, 1);
        run_vectors("wrap256");
        check("wrap ch_cnt[1] at 256", ch_cnt[CNT_W +: CNT_W], 0);
        add(4'b0010, 1, 1, 0, 1, 1, 2'd1, 1);
        add(4'b0010, 1, 0, 1, 1, 1, 2'd1, 0);
        run_vectors("clrxfer");
        check("clear beats increment", ch_cnt[CNT_W +: CNT_W], 0);
        add(4'b0010, 1, 1, 0, 1, 1, 2'd1, 1);
        add(4'hF, 1, 1, 0, 1, 1, 2'd1, 1);
        run_vectors("postclr");
        check("count after clear", ch_cnt[CNT_W +: CNT_W], 2);

        // Asynchronous reset mid-burst clears outputs without waiting for an edge.
        en_mask      = 4'hF;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        rst_n        = 1'b0;
        #1;
        check("midrst in_ready", bus.in_ready, 0);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst sel", bus.sel, 0);
        check("midrst I", bus.I, 0);
        check_cnts("midrst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add(4'hF, 1, 1, 0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 5; i++) add(4'hF, 1, 1, 0, 1, 1, (i < 4) ? 2'd0 : 2'd1, 1);
        run_vectors("restart");
        check_cnts("restart", 4, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
